// File: rtl/rev_tick_pkg.sv
// Shared types for the revolution tick generator.
package rev_tick_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SYNC,
        RUN,
        HOLD
    } rev_state_t;

endpackage

// File: rtl/frac_tick_accum.sv
// Bresenham-style fractional accumulator: adds TICKS_PER_REV each enabled cycle
// and signals a step whenever the running sum reaches the period.
module frac_tick_accum #(
    parameter int PERIOD_W      = 27,
    parameter int TICKS_PER_REV = 256
) (
    input  logic                clear_i,
    input  logic                enable_i,
    input  logic [PERIOD_W-1:0] period_i,
    input  logic [PERIOD_W-1:0] acc_i,
    output logic                step_o,
    output logic [PERIOD_W-1:0] acc_next_o
);

    localparam logic [PERIOD_W:0] STEP = (PERIOD_W+1)'(TICKS_PER_REV);

    logic [PERIOD_W:0] sum;

    // One extra bit on the sum so acc + TICKS_PER_REV never wraps before the compare.
    always_comb begin
        sum        = {1'b0, acc_i} + STEP;
        step_o     = 1'b0;
        acc_next_o = acc_i;
        if (clear_i) begin
            acc_next_o = '0;
        end else if (enable_i) begin
            if (sum >= {1'b0, period_i}) begin
                step_o     = 1'b1;
                acc_next_o = PERIOD_W'(sum - {1'b0, period_i});
            end else begin
                acc_next_o = sum[PERIOD_W-1:0];
            end
        end
    end

endmodule

// File: rtl/rev_tick_gen.sv
// Column-strobe generator: spreads TICKS_PER_REV ticks evenly over a measured
// revolution period and realigns to slot 0 on every accepted sync pulse.
module rev_tick_gen
    import rev_tick_pkg::*;
#(
    parameter int TICKS_PER_REV = 256,
    parameter int PERIOD_W      = 27
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             sync_in,
    input  logic [PERIOD_W-1:0]              period_in,
    input  logic                             period_valid_in,
    output logic                             tick_out,
    output logic [$clog2(TICKS_PER_REV)-1:0] slot_out,
    output logic                             locked_out,
    output logic                             err_out
);

    localparam int                SLOT_W     = $clog2(TICKS_PER_REV);
    localparam logic [PERIOD_W:0] MIN_PERIOD = (PERIOD_W+1)'(TICKS_PER_REV);
    localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(TICKS_PER_REV - 1);

    rev_state_t          state_q, state_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] pend_period_q, pend_period_d;
    logic                pending_q, pending_d;
    logic [PERIOD_W-1:0] acc_q;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic                tick_q, tick_d;
    logic                locked_q, locked_d;
    logic                err_q, err_d;

    logic                periodAccept;
    logic                periodReject;
    logic                accClear;
    logic                accEnable;
    logic                accStep;
    logic [PERIOD_W-1:0] accNext;
    logic [SLOT_W-1:0]   slotInc;

    frac_tick_accum #(
        .PERIOD_W      (PERIOD_W),
        .TICKS_PER_REV (TICKS_PER_REV)
    ) u_accum (
        .clear_i    (accClear),
        .enable_i   (accEnable),
        .period_i   (period_q),
        .acc_i      (acc_q),
        .step_o     (accStep),
        .acc_next_o (accNext)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= IDLE;
            period_q      <= '0;
            pend_period_q <= '0;
            pending_q     <= 1'b0;
            acc_q         <= '0;
            slot_q        <= '0;
            tick_q        <= 1'b0;
            locked_q      <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            period_q      <= period_d;
            pend_period_q <= pend_period_d;
            pending_q     <= pending_d;
            acc_q         <= accNext;
            slot_q        <= slot_d;
            tick_q        <= tick_d;
            locked_q      <= locked_d;
            err_q         <= err_d;
        end
    end

    // A sync consumes the old shadow; a period arriving in the same cycle stays pending.
    always_comb begin
        state_d       = state_q;
        period_d      = period_q;
        pend_period_d = pend_period_q;
        pending_d     = pending_q;
        slot_d        = slot_q;
        tick_d        = 1'b0;
        accClear      = 1'b0;
        accEnable     = 1'b0;
        slotInc       = slot_q + 1'b1;

        periodAccept  = period_valid_in && ({1'b0, period_in} >= MIN_PERIOD);
        periodReject  = period_valid_in && !periodAccept;
        err_d         = periodReject;

        if (periodAccept) begin
            pend_period_d = period_in;
            pending_d     = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (periodAccept) begin
                    state_d = WAIT_SYNC;
                end
            end
            WAIT_SYNC, RUN, HOLD: begin
                if (sync_in) begin
                    if (pending_q) begin
                        period_d = pend_period_q;
                    end
                    pending_d = periodAccept;
                    accClear  = 1'b1;
                    slot_d    = '0;
                    tick_d    = 1'b1;
                    state_d   = RUN;
                end else if (state_q == RUN) begin
                    accEnable = 1'b1;
                    if (accStep) begin
                        slot_d = slotInc;
                        tick_d = 1'b1;
                        if (slotInc == LAST_SLOT) begin
                            state_d = HOLD;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        locked_d = (state_d == RUN) || (state_d == HOLD);
    end

    assign tick_out   = tick_q;
    assign slot_out   = slot_q;
    assign locked_out = locked_q;
    assign err_out    = err_q;

endmodule

// File: doc/rev_tick_gen.md
# rev_tick_gen

Generates evenly spaced column-strobe events from a measured revolution period, so the display can index LED columns around each rotation. A once-per-revolution sync pulse realigns the generator to angle 0. The period input is supplied upstream in clock cycles per revolution, and each strobe carries its angular slot index. The strobe output drives the downstream event counters and the column frame-buffer read address.

## Interface
Parameters:
- `TICKS_PER_REV`, default 256: strobes per revolution; must be ≥ 2.
- `PERIOD_W`, default 27: width of the period value in clock cycles.

Ports:
- `clk_in`  input  1: system clock.
- `rst_in`  input  1: reset, synchronous, active-high.
- `sync_in`  input  1: one-cycle pulse at angle 0, already debounced.
- `period_in`  input  PERIOD_W: cycles per revolution.
- `period_valid_in`  input  1: single-cycle qualifier for `period_in`.
- `tick_out`  output  1: one-cycle column strobe.
- `slot_out`  output  $clog2(TICKS_PER_REV): slot index; valid whenever `tick_out`=1, otherwise holds the last value.
- `locked_out`  output  1: high while in RUN or HOLD.
- `err_out`  output  1: one-cycle pulse when a period is rejected.

## Operation
- Shadow register `pend_period` plus a pending flag. Active register `period`.
  - On `period_valid_in`:
    - if `period_in` < TICKS_PER_REV (this includes 0): reject, pulse `err_out` next cycle, shadow unchanged;
    - otherwise: load the shadow and set the pending flag.
  - The shadow is copied to `period` only on an accepted `sync_in`. The active period never changes mid-revolution.
- States: IDLE, WAIT_SYNC, RUN, HOLD.
  - IDLE: no pending period. Move to WAIT_SYNC once a period is accepted. `sync_in` is ignored.
  - WAIT_SYNC, RUN, HOLD on `sync_in`:
    - copy shadow to `period` if pending, clear the pending flag;
    - set acc=0 and slot=0;
    - emit tick with `slot_out`=0;
    - go to RUN.
  - RUN, cycle without sync, using sum = acc + TICKS_PER_REV (width PERIOD_W+1, no overflow):
    - if sum ≥ `period`: acc ← sum − `period`, slot ← slot+1, emit tick with the new slot;
    - else: acc ← sum.
    - After emitting slot TICKS_PER_REV−1, go to HOLD.
  - HOLD: no ticks and acc frozen until `sync_in`. Covers a slowing rotor; the slot never wraps to 0 without sync.
- Bresenham property: exactly TICKS_PER_REV ticks per `period` cycles. Spacing is floor or ceil of `period`/TICKS_PER_REV.
- Simultaneous `sync_in` and `period_valid_in`: the sync uses the old shadow; the new value is pending for the next sync.
- Sync arriving in RUN before all slots are emitted: the revolution is truncated and realigned to slot 0. Not an error.

## Timing
- Reset values: state IDLE; `tick_out`, `slot_out`, `locked_out`, `err_out`, acc and pending flag all 0; `period` = 0.
- All outputs are registered. An input sampled in cycle c affects outputs in cycle c+1.
- Sync latency: `sync_in` high in cycle s gives `tick_out`=1 with `slot_out`=0 in cycle s+1.
- `locked_out` rises in the cycle after the first accepted sync. It falls only on reset.
- Reset mid-revolution: the next cycle is IDLE with all outputs 0. The shadow is cleared.

## Structure
- Package `rev_tick_pkg`: state enum `rev_state_t` {IDLE, WAIT_SYNC, RUN, HOLD}.
- Sub-module `frac_tick_accum`: the accumulator and compare. Inputs: clear, enable, period. Outputs: the step pulse and the next acc.
- The FSM, period shadowing and slot counter stay in the top module.

## Test plan
- TICKS_PER_REV=4. Load period 10, then sync at cycle s. Ticks at s+1, s+4, s+6, s+9 with slots 0, 1, 2, 3. No tick at s+10 (HOLD). Next sync at s+10 gives a tick at s+11 with slot 0.
- TICKS_PER_REV=4, period 3 via `period_valid_in`. `err_out` pulses once, state remains IDLE, and no ticks follow a sync.
- Sync while in IDLE (no period loaded): no tick, `locked_out` stays 0.
- Period 10 active; load period 20 mid-revolution. Spacing stays at period 10 until the next sync, then 4 ticks are spread over 20 cycles (ticks at +1, +6, +11, +16).
- Sync arrives at s+5 during RUN, after slots 0 and 1. Tick with slot 0 at s+6; slots 2 and 3 are never emitted that revolution.
- Reset asserted during RUN. The next cycle has all outputs 0. A sync without a new period load produces no tick.
